// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage : execute stage of the 5-stage pipeline.
//
// Takes the decode register (opcode, rs/rt values, sign-extended immediate,
// destination index and PC). It computes the ALU result, the load/store
// address or the branch/JR outcome, and registers it toward MEM one cycle
// after acceptance. MUL/MULI use an iterative shift-add multiplier that
// retires MUL_BITS multiplier bits per cycle and holds decode via stall_out.
// An accepted HALT sets a sticky halted flag. After that no further results
// are produced until reset.
//
// Optional build macro:
//   EX_FAST_MUL_EN  defined   -> single-cycle combinational MUL/MULI. No FSM,
//                                no counter, and stall_out is tied to 0.
//                   undefined -> iterative multiplier, 32/MUL_BITS MUL cycles.
//
// Handshake: the instruction on the *_in ports is taken when valid_in=1,
// the stage is idle and not halted. For a MUL, stall_out rises in the same
// cycle the MUL is taken. Decode therefore keeps presenting the consumed MUL
// until stall_out drops. Those held inputs are ignored while the multiply
// runs. Decode advances on every clock edge where stall_out=0.
//
// Parameters: MUL_BITS (1,2,4,8,16,32), PC_W (<= 32).
// Ports:
//   clk, reset (async, active-low)
//   valid_in, opcode_in[5:0], rs_val_in, rt_val_in, imm_in, dest_idx_in[4:0],
//   pc_in[PC_W-1:0]                           -- decode register
//   stall_out                                 -- decode must hold
//   valid_out, opcode_out, result_out, store_data_out, dest_idx_out,
//   reg_write_out, mem_rd_out, mem_wr_out     -- EX/MEM register
//   br_taken_out, br_target_out               -- fetch redirect (1-cycle pulse)
//   halt_out                                  -- sticky halted flag
//   o_dbg_mul_busy                            -- multiplier FSM is in MUL state
// ---------------------------------------------------------------------------
module ex_stage #(
    parameter int MUL_BITS = 4,
    parameter int PC_W     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [5:0]      opcode_in,
    input  logic [31:0]     rs_val_in,
    input  logic [31:0]     rt_val_in,
    input  logic [31:0]     imm_in,
    input  logic [4:0]      dest_idx_in,
    input  logic [PC_W-1:0] pc_in,
    output logic            stall_out,
    output logic            valid_out,
    output logic [5:0]      opcode_out,
    output logic [31:0]     result_out,
    output logic [31:0]     store_data_out,
    output logic [4:0]      dest_idx_out,
    output logic            reg_write_out,
    output logic            mem_rd_out,
    output logic            mem_wr_out,
    output logic            br_taken_out,
    output logic [PC_W-1:0] br_target_out,
    output logic            halt_out,
    output logic            o_dbg_mul_busy
);

    localparam logic [5:0] OP_ADD  = 6'd0,  OP_SUB  = 6'd1,  OP_OR   = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3,  OP_XOR  = 6'd4,  OP_ADDI = 6'd5;
    localparam logic [5:0] OP_SUBI = 6'd6,  OP_ORI  = 6'd7,  OP_ANDI = 6'd8;
    localparam logic [5:0] OP_XORI = 6'd9,  OP_MUL  = 6'd10, OP_MULI = 6'd11;
    localparam logic [5:0] OP_LDW  = 6'd12, OP_STW  = 6'd13, OP_BZ   = 6'd14;
    localparam logic [5:0] OP_BEQ  = 6'd15, OP_JR   = 6'd16, OP_HALT = 6'd17;

    logic            r_halted;
    logic            w_accept;
    logic            w_is_mul;
    logic [31:0]     w_mul_b;
    logic [31:0]     w_result;
    logic [31:0]     w_store;
    logic            w_reg_write;
    logic            w_mem_rd;
    logic            w_mem_wr;
    logic            w_br_taken;
    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_br_off;

    assign halt_out = r_halted;
    assign w_is_mul = (opcode_in == OP_MUL) || (opcode_in == OP_MULI);
    assign w_mul_b  = (opcode_in == OP_MULI) ? imm_in : rt_val_in;
    assign w_br_off = {imm_in[PC_W-3:0], 2'b00};

    // Single-cycle result for every opcode. In the iterative build, MUL/MULI
    // leave these at their zero defaults and take the FSM path instead.
    always_comb begin
        w_result    = '0;
        w_store     = '0;
        w_reg_write = 1'b0;
        w_mem_rd    = 1'b0;
        w_mem_wr    = 1'b0;
        w_br_taken  = 1'b0;
        w_br_target = '0;
        case (opcode_in)
            OP_ADD:  begin w_result = rs_val_in + rt_val_in; w_reg_write = 1'b1; end
            OP_SUB:  begin w_result = rs_val_in - rt_val_in; w_reg_write = 1'b1; end
            OP_OR:   begin w_result = rs_val_in | rt_val_in; w_reg_write = 1'b1; end
            OP_AND:  begin w_result = rs_val_in & rt_val_in; w_reg_write = 1'b1; end
            OP_XOR:  begin w_result = rs_val_in ^ rt_val_in; w_reg_write = 1'b1; end
            OP_ADDI: begin w_result = rs_val_in + imm_in;    w_reg_write = 1'b1; end
            OP_SUBI: begin w_result = rs_val_in - imm_in;    w_reg_write = 1'b1; end
            OP_ORI:  begin w_result = rs_val_in | imm_in;    w_reg_write = 1'b1; end
            OP_ANDI: begin w_result = rs_val_in & imm_in;    w_reg_write = 1'b1; end
            OP_XORI: begin w_result = rs_val_in ^ imm_in;    w_reg_write = 1'b1; end
`ifdef EX_FAST_MUL_EN
            OP_MUL, OP_MULI: begin
                w_result    = rs_val_in * w_mul_b;
                w_reg_write = 1'b1;
            end
`endif
            OP_LDW:  begin w_result = rs_val_in + imm_in; w_reg_write = 1'b1; w_mem_rd = 1'b1; end
            OP_STW:  begin
                w_result = rs_val_in + imm_in;
                w_store  = rt_val_in;
                w_mem_wr = 1'b1;
            end
            OP_BZ:   begin
                w_br_taken  = (rs_val_in == 32'd0);
                w_br_target = pc_in + w_br_off;
            end
            OP_BEQ:  begin
                w_br_taken  = (rs_val_in == rt_val_in);
                w_br_target = pc_in + w_br_off;
            end
            OP_JR:   begin
                w_br_taken  = 1'b1;
                w_br_target = rs_val_in[PC_W-1:0];
            end
            default: ;  // HALT and unknown opcodes: no writes, no branch, result 0
        endcase
    end

`ifdef EX_FAST_MUL_EN

    assign w_accept       = valid_in && !r_halted;
    assign stall_out      = 1'b0;
    assign o_dbg_mul_busy = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_halted       <= 1'b0;
            valid_out      <= 1'b0;
            opcode_out     <= '0;
            result_out     <= '0;
            store_data_out <= '0;
            dest_idx_out   <= '0;
            reg_write_out  <= 1'b0;
            mem_rd_out     <= 1'b0;
            mem_wr_out     <= 1'b0;
            br_taken_out   <= 1'b0;
            br_target_out  <= '0;
        end else begin
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
            mem_rd_out    <= 1'b0;
            mem_wr_out    <= 1'b0;
            br_taken_out  <= 1'b0;
            if (w_accept) begin
                valid_out      <= 1'b1;
                opcode_out     <= opcode_in;
                result_out     <= w_result;
                store_data_out <= w_store;
                dest_idx_out   <= dest_idx_in;
                reg_write_out  <= w_reg_write;
                mem_rd_out     <= w_mem_rd;
                mem_wr_out     <= w_mem_wr;
                br_taken_out   <= w_br_taken;
                br_target_out  <= w_br_target;
                if (opcode_in == OP_HALT) r_halted <= 1'b1;
            end
        end
    end

`else

    typedef enum logic {S_IDLE, S_MUL} state_t;

    localparam int MUL_STEPS = 32 / MUL_BITS;
    localparam int CNT_W     = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_mcand;   // multiplicand, pre-shifted to the current bit weight
    logic [31:0]      r_mplier;  // remaining multiplier bits, low chunk first
    logic [31:0]      r_acc;
    logic [5:0]       r_mul_op;
    logic [4:0]       r_mul_dest;
    logic [31:0]      w_partial;
    logic             w_last;

    // The stage only takes work in IDLE. The MUL that is still being held
    // by decode during the multiply is therefore never taken a second time.
    assign w_accept       = valid_in && !r_halted && (r_state == S_IDLE);
    assign w_last         = (r_state == S_MUL) && (r_cnt == CNT_LAST);
    assign stall_out      = (w_accept && w_is_mul) || ((r_state == S_MUL) && !w_last);
    assign o_dbg_mul_busy = (r_state == S_MUL);

    // Shift-add over this cycle's MUL_BITS multiplier bits (low word only).
    always_comb begin
        w_partial = '0;
        for (int b = 0; b < MUL_BITS; b++) begin
            if (r_mplier[b]) w_partial = w_partial + (r_mcand << b);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_acc          <= '0;
            r_mul_op       <= '0;
            r_mul_dest     <= '0;
            r_halted       <= 1'b0;
            valid_out      <= 1'b0;
            opcode_out     <= '0;
            result_out     <= '0;
            store_data_out <= '0;
            dest_idx_out   <= '0;
            reg_write_out  <= 1'b0;
            mem_rd_out     <= 1'b0;
            mem_wr_out     <= 1'b0;
            br_taken_out   <= 1'b0;
            br_target_out  <= '0;
        end else begin
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
            mem_rd_out    <= 1'b0;
            mem_wr_out    <= 1'b0;
            br_taken_out  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_state    <= S_MUL;
                        r_cnt      <= '0;
                        r_mcand    <= rs_val_in;
                        r_mplier   <= w_mul_b;
                        r_acc      <= '0;
                        r_mul_op   <= opcode_in;
                        r_mul_dest <= dest_idx_in;
                    end else if (w_accept) begin
                        valid_out      <= 1'b1;
                        opcode_out     <= opcode_in;
                        result_out     <= w_result;
                        store_data_out <= w_store;
                        dest_idx_out   <= dest_idx_in;
                        reg_write_out  <= w_reg_write;
                        mem_rd_out     <= w_mem_rd;
                        mem_wr_out     <= w_mem_wr;
                        br_taken_out   <= w_br_taken;
                        br_target_out  <= w_br_target;
                        if (opcode_in == OP_HALT) r_halted <= 1'b1;
                    end
                end
                S_MUL: begin
                    r_acc    <= r_acc + w_partial;
                    r_mcand  <= r_mcand << MUL_BITS;
                    r_mplier <= r_mplier >> MUL_BITS;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state        <= S_IDLE;
                        valid_out      <= 1'b1;
                        opcode_out     <= r_mul_op;
                        result_out     <= r_acc + w_partial;
                        store_data_out <= '0;
                        dest_idx_out   <= r_mul_dest;
                        reg_write_out  <= 1'b1;
                        br_target_out  <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage : scoreboard bench for ex_stage.
// A decode-register driver presents instructions and advances only on edges
// where stall_out=0. For each instruction the ex_stage should take, it
// pushes the reference-model result into exp_q. A negedge monitor pops one
// entry from exp_q on every valid_out and compares it with the outputs.
// ---------------------------------------------------------------------------
module tb_ex_stage;
    localparam int MUL_BITS = 4;
    localparam int PC_W     = 32;
`ifdef EX_FAST_MUL_EN
    localparam int MUL_STALLS = 0;
`else
    localparam int MUL_STALLS = 32 / MUL_BITS;
`endif

    localparam logic [5:0] OP_ADD = 6'd0, OP_ADDI = 6'd5, OP_MUL = 6'd10, OP_MULI = 6'd11;
    localparam logic [5:0] OP_STW = 6'd13, OP_BZ = 6'd14, OP_BEQ = 6'd15, OP_HALT = 6'd17;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic            valid_in = 1'b0;
    logic [5:0]      opcode_in = '0;
    logic [31:0]     rs_val_in = '0, rt_val_in = '0, imm_in = '0;
    logic [4:0]      dest_idx_in = '0;
    logic [PC_W-1:0] pc_in = '0;
    logic            stall_out, valid_out, reg_write_out, mem_rd_out, mem_wr_out;
    logic            br_taken_out, halt_out, o_dbg_mul_busy;
    logic [5:0]      opcode_out;
    logic [31:0]     result_out, store_data_out;
    logic [4:0]      dest_idx_out;
    logic [PC_W-1:0] br_target_out;

    ex_stage #(.MUL_BITS(MUL_BITS), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .opcode_in(opcode_in),
        .rs_val_in(rs_val_in), .rt_val_in(rt_val_in), .imm_in(imm_in),
        .dest_idx_in(dest_idx_in), .pc_in(pc_in), .stall_out(stall_out),
        .valid_out(valid_out), .opcode_out(opcode_out), .result_out(result_out),
        .store_data_out(store_data_out), .dest_idx_out(dest_idx_out),
        .reg_write_out(reg_write_out), .mem_rd_out(mem_rd_out), .mem_wr_out(mem_wr_out),
        .br_taken_out(br_taken_out), .br_target_out(br_target_out), .halt_out(halt_out),
        .o_dbg_mul_busy(o_dbg_mul_busy)
    );

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  dest;
        logic        rw, mrd, mwr, br;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e, mon_a;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_halted = 1'b0;

    // Reference model: architectural meaning of each opcode.
    function automatic exp_t ref_exec(input logic [5:0] op, input logic [31:0] rs,
                                      input logic [31:0] rt, input logic [31:0] imm,
                                      input logic [4:0] dest, input logic [31:0] pc);
        exp_t e;
        e = '0;
        e.op = op;
        e.dest = dest;
        case (op)
            6'd0:  begin e.res = rs + rt;  e.rw = 1'b1; end
            6'd1:  begin e.res = rs - rt;  e.rw = 1'b1; end
            6'd2:  begin e.res = rs | rt;  e.rw = 1'b1; end
            6'd3:  begin e.res = rs & rt;  e.rw = 1'b1; end
            6'd4:  begin e.res = rs ^ rt;  e.rw = 1'b1; end
            6'd5:  begin e.res = rs + imm; e.rw = 1'b1; end
            6'd6:  begin e.res = rs - imm; e.rw = 1'b1; end
            6'd7:  begin e.res = rs | imm; e.rw = 1'b1; end
            6'd8:  begin e.res = rs & imm; e.rw = 1'b1; end
            6'd9:  begin e.res = rs ^ imm; e.rw = 1'b1; end
            6'd10: begin e.res = rs * rt;  e.rw = 1'b1; end
            6'd11: begin e.res = rs * imm; e.rw = 1'b1; end
            6'd12: begin e.res = rs + imm; e.rw = 1'b1; e.mrd = 1'b1; end
            6'd13: begin e.res = rs + imm; e.sd = rt; e.mwr = 1'b1; end
            6'd14: begin e.br = (rs == 0);  e.tgt = pc + (imm << 2); end
            6'd15: begin e.br = (rs == rt); e.tgt = pc + (imm << 2); end
            6'd16: begin e.br = 1'b1; e.tgt = rs; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: opcode_out=%0h result_out=%0h, none expected",
                             opcode_out, result_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_a = '{op: opcode_out, res: result_out, sd: store_data_out,
                              dest: dest_idx_out, rw: reg_write_out, mrd: mem_rd_out,
                              mwr: mem_wr_out, br: br_taken_out,
                              tgt: br_taken_out ? br_target_out : 32'd0};
                    if (!mon_e.br) mon_e.tgt = '0;
                    check("ex_result", 128'(mon_a), 128'(mon_e));
                end
            end else begin
                check("idle_controls", 128'({br_taken_out, reg_write_out, mem_rd_out, mem_wr_out}),
                      128'(0));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one instruction and holds it until an edge with stall_out=0.
    task automatic issue(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic [4:0] dest, input logic [31:0] pc);
        int   stalls;
        int   exp_stalls;
        logic st;
        opcode_in = op; rs_val_in = rs; rt_val_in = rt; imm_in = imm;
        dest_idx_in = dest; pc_in = pc; valid_in = 1'b1;
        exp_stalls = 0;
        if (!m_halted) begin
            exp_q.push_back(ref_exec(op, rs, rt, imm, dest, pc));
            if (op == OP_MUL || op == OP_MULI) exp_stalls = MUL_STALLS;
            if (op == OP_HALT) m_halted = 1'b1;
        end
        stalls = 0;
        forever begin
            @(negedge clk);
            st = stall_out;
            @(posedge clk);
            #1;
            if (!st) break;
            stalls++;
            if (stalls > 100) break;
        end
        check("stall_cycles", 128'(stalls), 128'(exp_stalls));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [5:0]  op;
        logic [31:0] rs, rt, imm, pc;
        logic [15:0] imm16;

        repeat (3) @(negedge clk);
        check("reset_outputs",
              128'({valid_out, opcode_out, result_out, store_data_out, dest_idx_out,
                    reg_write_out, mem_rd_out, mem_wr_out, br_taken_out, br_target_out,
                    halt_out, stall_out, o_dbg_mul_busy}), 128'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ADDI 5 + (-3)
        issue(OP_ADDI, 32'd5, 32'd0, 32'hFFFF_FFFD, 5'd1, 32'h0);
        check("addi_result", 128'({valid_out, reg_write_out, result_out}), 128'({2'b11, 32'd2}));

        // MUL 7*6, then an ADD presented right after the stall drops
        issue(OP_MUL, 32'd7, 32'd6, 32'd0, 5'd2, 32'h4);
        check("mul_result", 128'({valid_out, result_out}), 128'({1'b1, 32'd42}));
        issue(OP_ADD, 32'd10, 32'd20, 32'd0, 5'd3, 32'h8);
        check("add_after_mul", 128'({valid_out, result_out}), 128'({1'b1, 32'd30}));

        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd4, 32'hC);
        check("mul_all_ones", 128'(result_out), 128'(32'd1));

        issue(OP_BEQ, 32'd9, 32'd9, 32'd3, 5'd0, 32'h100);
        check("beq_taken", 128'({br_taken_out, br_target_out, reg_write_out}),
              128'({1'b1, 32'h10C, 1'b0}));
        issue(OP_BZ, 32'd1, 32'd0, 32'd3, 5'd0, 32'h104);
        check("bz_not_taken", 128'({valid_out, br_taken_out}), 128'(2'b10));
        idle(1);
        check("br_pulse_cleared", 128'(br_taken_out), 128'(0));

        issue(OP_STW, 32'h20, 32'hAB, 32'd4, 5'd7, 32'h108);
        check("stw_fields", 128'({result_out, store_data_out, mem_wr_out, reg_write_out}),
              128'({32'h24, 32'hAB, 1'b1, 1'b0}));
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 120; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r <= 16) op = 6'(r);
            else op = 6'($urandom_range(18, 63));
            rs = pick_operand();
            rt = pick_operand();
            if (op == OP_BEQ && $urandom_range(0, 1) == 1) rt = rs;
            imm16 = 16'($urandom);
            imm = {{16{imm16[15]}}, imm16};
            pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            issue(op, rs, rt, imm, 5'($urandom_range(0, 31)), pc);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        // Reset during the multiply
        opcode_in = OP_MUL; rs_val_in = 32'd3; rt_val_in = 32'd5; valid_in = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        reset = 1'b0;
        #1;
        check("reset_mid_mul",
              128'({valid_out, opcode_out, result_out, store_data_out, dest_idx_out,
                    reg_write_out, mem_rd_out, mem_wr_out, br_taken_out, br_target_out,
                    halt_out, stall_out, o_dbg_mul_busy}), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        issue(OP_ADD, 32'd1, 32'd1, 32'd0, 5'd9, 32'h200);
        check("add_after_reset", 128'({valid_out, result_out}), 128'({1'b1, 32'd2}));

        // HALT, then work that must be ignored
        issue(OP_HALT, 32'd0, 32'd0, 32'd0, 5'd0, 32'h204);
        check("halt_visible", 128'({valid_out, opcode_out, halt_out}), 128'({1'b1, OP_HALT, 1'b1}));
        issue(OP_ADD, 32'd4, 32'd4, 32'd0, 5'd10, 32'h208);
        issue(OP_MUL, 32'd4, 32'd4, 32'd0, 5'd11, 32'h20C);
        idle(4);
        check("halt_sticky", 128'({halt_out, valid_out}), 128'(2'b10));
        check("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    // Overall time bound on the run.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
